// File: rtl/semaforo_pkg.sv
// semaforo_pkg: light-state encodings shared with semaforo, plus a counter-width helper
package semaforo_pkg;
  localparam logic [1:0] VERDE    = 2'b00;
  localparam logic [1:0] AMARELO  = 2'b01;
  localparam logic [1:0] VERMELHO = 2'b10;
  function automatic int largura(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/filtro_debounce.sv
// filtro_debounce: 2-flop synchroniser plus debounce counter for a bouncy panel switch
module filtro_debounce import semaforo_pkg::*; #(
  parameter int DEB_CICLOS = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic estavel
);
  localparam int CW = largura(DEB_CICLOS);
  logic meta_q, sinc_q, estavel_q, estavel_d, diferente, cheio;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diferente = sinc_q != estavel_q;
    cheio     = cnt_q == CW'(DEB_CICLOS);
    estavel_d = diferente && cheio ? sinc_q : estavel_q;
    cnt_d     = diferente && !cheio ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q    <= 1'b0;
      sinc_q    <= 1'b0;
      estavel_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      meta_q    <= entrada;
      sinc_q    <= meta_q;
      estavel_q <= estavel_d;
      cnt_q     <= cnt_d;
    end
  end
  assign estavel = estavel_q;
endmodule

// File: rtl/condiciona_botao.sv
// condiciona_botao: turns the raw pedestrian button into a single-cycle request issued on green,
// followed by a lockout window so a held or hammered button cannot keep extending green.
module condiciona_botao import semaforo_pkg::*; #(
  parameter int DEB_CICLOS  = 16,
  parameter int BLOQ_CICLOS = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_bruto,
  input  logic [1:0] estado,
  output logic       botao,
  output logic       pendente,
  output logic       estavel
);
  typedef enum logic [1:0] {OCIOSO, PENDENTE, EMITE, BLOQUEIO} fase_t;
  localparam int BW = largura(BLOQ_CICLOS);
  localparam logic [BW-1:0] CARGA = BW'(BLOQ_CICLOS > 0 ? BLOQ_CICLOS - 1 : 0);
  fase_t fase_q, fase_d;
  logic [BW-1:0] bloq_q, bloq_d;
  logic [1:0] estado_q;
  logic estavel_ant_q, subida;
  filtro_debounce #(.DEB_CICLOS(DEB_CICLOS)) u_filtro (
    .clock   (clock),
    .reset   (reset),
    .entrada (botao_bruto),
    .estavel (estavel)
  );
  // the green decision uses the registered light state, so a request waits one edge after green is seen
  always_comb begin
    subida = estavel & ~estavel_ant_q;
    fase_d = fase_q;
    bloq_d = bloq_q;
    case (fase_q)
      OCIOSO:   fase_d = subida ? PENDENTE : OCIOSO;
      PENDENTE: fase_d = estado_q == VERDE ? EMITE : PENDENTE;
      EMITE: begin
        fase_d = BLOQ_CICLOS > 0 ? BLOQUEIO : OCIOSO;
        bloq_d = CARGA;
      end
      default: begin
        fase_d = bloq_q == '0 ? OCIOSO : BLOQUEIO;
        bloq_d = bloq_q == '0 ? '0 : bloq_q - 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fase_q        <= OCIOSO;
      bloq_q        <= '0;
      estado_q      <= '0;
      estavel_ant_q <= 1'b0;
    end else begin
      fase_q        <= fase_d;
      bloq_q        <= bloq_d;
      estado_q      <= estado;
      estavel_ant_q <= estavel;
    end
  end
  assign botao    = fase_q == EMITE;
  assign pendente = fase_q == PENDENTE;
endmodule

// File: tb/tb_condiciona_botao.sv
// tb_condiciona_botao: directed steps with a queue of expected botao pulse cycles
module tb_condiciona_botao;
  logic       clock = 1'b0, reset = 1'b0, botao_bruto = 1'b0;
  logic [1:0] estado = 2'b00;
  logic       botao, pendente, estavel;
  int ciclo = 0, testes = 0, falhas = 0;
  int esperados[$];
  int c0, n;

  condiciona_botao #(.DEB_CICLOS(4), .BLOQ_CICLOS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .botao_bruto (botao_bruto),
    .estado      (estado),
    .botao       (botao),
    .pendente    (pendente),
    .estavel     (estavel)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    assert (obs === esp) else begin
      falhas++;
      $error("FAIL %s: obtido %0d esperado %0d", tag, obs, esp);
    end
  endtask

  task automatic avanca(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic ate(input int c);
    while (ciclo < c) avanca(1);
  endtask

  // every botao pulse must match the front of the queue; a pulse with nothing queued is an error
  always @(negedge clock) begin
    if (botao !== 1'b0) begin
      if (esperados.size() == 0) confere("botao_inesperado", 32'(botao), 0);
      else confere("botao_ciclo", ciclo, esperados.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulacao nao terminou");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      botao_bruto = 1'($urandom_range(1));
      estado = 2'($urandom_range(3));
      avanca(1);
    end
    confere("reset_botao", 32'(botao), 0);
    confere("reset_pendente", 32'(pendente), 0);
    confere("reset_estavel", 32'(estavel), 0);
    botao_bruto = 1'b0;
    estado = 2'b00;
    avanca(1);
    reset = 1'b1;
    avanca(5);
    confere("pos_reset_botao", 32'(botao), 0);
    confere("pos_reset_pendente", 32'(pendente), 0);
    confere("pos_reset_estavel", 32'(estavel), 0);

    c0 = ciclo + 1;
    botao_bruto = 1'b1;
    esperados.push_back(c0 + 8);
    ate(c0 + 5);
    confere("limpo_estavel_cedo", 32'(estavel), 0);
    ate(c0 + 6);
    confere("limpo_estavel", 32'(estavel), 1);
    confere("limpo_pendente_cedo", 32'(pendente), 0);
    ate(c0 + 7);
    confere("limpo_pendente", 32'(pendente), 1);
    ate(c0 + 8);
    confere("limpo_botao", 32'(botao), 1);
    confere("limpo_pendente_fim", 32'(pendente), 0);
    ate(c0 + 20);
    botao_bruto = 1'b0;
    avanca(20);

    for (int i = 0; i < 16; i++) begin
      botao_bruto = (i % 4) != 3;
      avanca(1);
      confere("ressalto_estavel", 32'(estavel), 0);
      confere("ressalto_pendente", 32'(pendente), 0);
    end
    botao_bruto = 1'b0;
    avanca(10);
    confere("ressalto_estavel_fim", 32'(estavel), 0);
    c0 = ciclo + 1;
    botao_bruto = 1'b1;
    esperados.push_back(c0 + 8);
    ate(c0 + 8);
    confere("ressalto_botao", 32'(botao), 1);
    ate(c0 + 20);
    botao_bruto = 1'b0;
    avanca(20);

    estado = 2'b10;
    c0 = ciclo + 1;
    botao_bruto = 1'b1;
    ate(c0 + 7);
    confere("adiado_pendente", 32'(pendente), 1);
    for (int i = 0; i < 40; i++) begin
      if (i == 5) botao_bruto = 1'b0;
      if (i == 15) botao_bruto = 1'b1;
      if (i == 20) estado = 2'b11;
      avanca(1);
      confere("adiado_espera_pendente", 32'(pendente), 1);
      confere("adiado_espera_botao", 32'(botao), 0);
    end
    estado = 2'b00;
    n = ciclo + 1;
    esperados.push_back(n + 1);
    ate(n);
    confere("adiado_pendente_n", 32'(pendente), 1);
    ate(n + 1);
    confere("adiado_botao", 32'(botao), 1);
    confere("adiado_pendente_fim", 32'(pendente), 0);
    ate(n + 2);
    confere("adiado_botao_fim", 32'(botao), 0);
    botao_bruto = 1'b0;
    avanca(30);

    c0 = ciclo + 1;
    botao_bruto = 1'b1;
    esperados.push_back(c0 + 8);
    ate(c0 + 4);
    botao_bruto = 1'b0;
    ate(c0 + 9);
    botao_bruto = 1'b1;
    ate(c0 + 11);
    confere("bloqueio_estavel_baixo", 32'(estavel), 0);
    ate(c0 + 16);
    confere("bloqueio_estavel_alto", 32'(estavel), 1);
    for (int i = 0; i < 20; i++) begin
      avanca(1);
      confere("bloqueio_pendente", 32'(pendente), 0);
    end
    botao_bruto = 1'b0;
    avanca(15);
    confere("bloqueio_solto", 32'(estavel), 0);
    c0 = ciclo + 1;
    botao_bruto = 1'b1;
    esperados.push_back(c0 + 8);
    ate(c0 + 8);
    confere("bloqueio_novo_botao", 32'(botao), 1);
    ate(c0 + 12);
    botao_bruto = 1'b0;
    avanca(25);

    estado = 2'b10;
    c0 = ciclo + 1;
    botao_bruto = 1'b1;
    ate(c0 + 7);
    confere("assinc_pendente", 32'(pendente), 1);
    #2 reset = 1'b0;
    #1;
    confere("assinc_pendente_cai", 32'(pendente), 0);
    confere("assinc_estavel_cai", 32'(estavel), 0);
    confere("assinc_botao", 32'(botao), 0);
    botao_bruto = 1'b0;
    estado = 2'b00;
    avanca(2);
    reset = 1'b1;
    avanca(50);
    confere("assinc_pendente_fim", 32'(pendente), 0);
    confere("assinc_estavel_fim", 32'(estavel), 0);

    confere("fila_vazia", esperados.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end
endmodule
